// File: rtl/kuz_pkg.sv
// Shared definitions for the Kuznyechik linear layer: l coefficients,
// default reduction polynomial, constant GF(2^8) multiply, FSM states.
package kuz_pkg;

    localparam logic [7:0] POLY_DEFAULT = 8'hC3;

    // l coefficients, indexed by byte position: L_COEF[15] multiplies a15,
    // L_COEF[0] multiplies a0. This is the sequence of the standardised l
    // (a0 carries weight 1), which is what makes R invertible as R^-1.
    localparam logic [7:0] L_COEF [15:0] = '{
        8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shift-and-add multiply in GF(2^8); with a constant c this folds to XORs.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a,
                                                input logic [7:0] c,
                                                input logic [7:0] poly);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ poly) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

endpackage

// File: rtl/kuz_r_step.sv
// One combinational R (inverse=0) or R^-1 (inverse=1) step.
module kuz_r_step
    import kuz_pkg::*;
#(
    parameter logic [7:0] POLY = POLY_DEFAULT
) (
    input  logic [127:0] din,
    input  logic         inverse,
    output logic [127:0] dout
);

    logic [127:0] l_arg;
    logic [7:0]   l_val;

    // R^-1 feeds l with (a14..a0, a15) so the recovered byte lands in a0.
    always_comb begin
        l_arg = inverse ? {din[119:0], din[127:120]} : din;
        l_val = 8'h00;
        for (int i = 0; i < 16; i++) begin
            l_val = l_val ^ gf_mul_const(l_arg[8*i +: 8], L_COEF[i], POLY);
        end
        dout = inverse ? {din[119:0], l_val} : {l_val, din[127:8]};
    end

endmodule

// File: rtl/kuz_l_engine.sv
// Kuznyechik L / L^-1 engine with valid/ready on both sides.
// Optional macro KUZ_L_SINGLE_R_EN adds in_single for one-step debug runs.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | in_ready=1, waiting for a block
// RUN   | applying ROUNDS_PER_CYCLE steps per clock until 16 done
// DONE  | out_valid=1, holding out_word until out_ready
module kuz_l_engine
    import kuz_pkg::*;
#(
    parameter int         ROUNDS_PER_CYCLE = 1,
    parameter logic [7:0] POLY             = POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inverse,
    input  logic [127:0] in_word,
`ifdef KUZ_L_SINGLE_R_EN
    input  logic         in_single,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_word,
    output logic         busy
);

    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("kuz_l_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t       state;
    logic [127:0] data_q;
    logic         mode_q;
    logic [4:0]   cnt_q;
    logic [127:0] next_data;
    logic [4:0]   next_cnt;
    logic [127:0] chain [ROUNDS_PER_CYCLE+1];

    assign chain[0] = data_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_step
        kuz_r_step #(.POLY(POLY)) u_step (
            .din     (chain[g]),
            .inverse (mode_q),
            .dout    (chain[g+1])
        );
    end

`ifdef KUZ_L_SINGLE_R_EN
    logic single_q;

    // Single mode takes the first step's output and finishes in one RUN cycle.
    always_comb begin
        next_data = single_q ? chain[1] : chain[ROUNDS_PER_CYCLE];
        next_cnt  = single_q ? 5'd16 : cnt_q + STEP;
    end

    // Debug mode flag is captured alongside the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) single_q <= 1'b0;
        else if (state == ST_IDLE && in_valid && in_ready) single_q <= in_single;
    end
`else
    // Result of this cycle's chained steps and the advanced round count.
    always_comb begin
        next_data = chain[ROUNDS_PER_CYCLE];
        next_cnt  = cnt_q + STEP;
    end
`endif

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_word  <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_word;
                        mode_q   <= in_inverse;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    data_q <= next_data;
                    cnt_q  <= next_cnt;
                    if (next_cnt == 5'd16) begin
                        out_word  <= next_data;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
